// File: rtl/data_mem_responder_if.sv
`default_nettype none
// =============================================================================
// Module      : data_mem_responder_if
// Description : Load/store request and response bundle between the core-side
//               requester (master) and the memory responder (slave).
//               req_strb is present only when BYTE_WRITE_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef BYTE_WRITE_EN
    logic [3:0]  req_strb;
`endif
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
`ifdef BYTE_WRITE_EN
        output req_strb,
`endif
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
`ifdef BYTE_WRITE_EN
        input  req_strb,
`endif
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// =============================================================================
// Module      : data_mem_responder
// Description : Word-addressed synchronous RAM behind a valid/ready port with
//               WAIT_CYCLES wait states, one response pulse per request and
//               misaligned/out-of-range error flagging. Optional byte-lane
//               write strobes when the BYTE_WRITE_EN macro is defined.
// Revision    : 1.0 - initial release
// =============================================================================
module data_mem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  wire logic           clka,
    input  wire logic           rst,
    data_mem_responder_if.slave bus
);
    localparam logic [1:0]  S_IDLE      = 2'd0;
    localparam logic [1:0]  S_BUSY      = 2'd1;
    localparam logic [1:0]  S_RESP      = 2'd2;
    localparam logic [3:0]  c_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] c_DEPTH     = 32'(DEPTH);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_strb;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_commit;
    logic              w_cmt_we;
    logic [31:0]       w_cmt_addr;
    logic [31:0]       w_cmt_wdata;
    logic [3:0]        w_cmt_strb;
    logic [3:0]        w_req_strb;
    logic [31:0]       w_off;
    logic              w_err;
    logic [ADDR_W-1:0] w_idx;

`ifdef BYTE_WRITE_EN
    assign w_req_strb = bus.req_strb;
`else
    assign w_req_strb = 4'hF;
`endif

    assign bus.req_ready = (r_state == S_IDLE);
    assign w_accept      = bus.req_valid && (r_state == S_IDLE);

    // With no wait states the accept edge is also the commit edge, so the
    // live request fields feed the array instead of the latched copies.
    generate
        if (WAIT_CYCLES == 0) begin : g_commit_on_accept
            assign w_commit    = w_accept;
            assign w_cmt_we    = bus.req_we;
            assign w_cmt_addr  = bus.req_addr;
            assign w_cmt_wdata = bus.req_wdata;
            assign w_cmt_strb  = w_req_strb;
        end else begin : g_commit_after_wait
            assign w_commit    = (r_state == S_BUSY) && (r_cnt == 4'd0);
            assign w_cmt_we    = r_we;
            assign w_cmt_addr  = r_addr;
            assign w_cmt_wdata = r_wdata;
            assign w_cmt_strb  = r_strb;
        end
    endgenerate

    assign w_off = w_cmt_addr - BASE_ADDR;
    assign w_err = (w_cmt_addr[1:0] != 2'b00) || (w_cmt_addr < BASE_ADDR) ||
                   ((w_off >> 2) >= c_DEPTH);
    assign w_idx = w_off[ADDR_W+1:2];

    always_ff @(posedge clka) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_strb      <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_strb  <= w_req_strb;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= c_WAIT_LOAD;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || w_cmt_we) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Array is deliberately not reset; a reset on the commit edge blocks the write.
    always_ff @(posedge clka) begin
        if (!rst && w_commit && w_cmt_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_cmt_strb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_cmt_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// =============================================================================
// Module      : tb_data_mem_responder
// Description : Randomized and directed bench for data_mem_responder against
//               a cycle-level transaction model (BYTE_WRITE_EN aware).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_data_mem_responder;
    localparam int          DEPTH  = 256;
    localparam int          ADDR_W = 8;
    localparam int          W      = 2;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic clka = 1'b0;
    logic rst  = 1'b1;
    always #5 clka = ~clka;

    data_mem_responder_if bus_if ();

    data_mem_responder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(W), .BASE_ADDR(BASE)
    ) dut (
        .clka(clka),
        .rst (rst),
        .bus (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // ---------------- transaction-level model ----------------
    int          cyc        = 0;
    int          free_cyc   = 0;
    bit          m_ready    = 1'b0;
    bit          chk_en     = 1'b0;
    bit          pend       = 1'b0;
    int          commit_at  = 0;
    bit          p_we;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_strb;
    bit          m_exp_valid = 1'b0;
    logic [31:0] m_exp_rdata = 32'd0;
    bit          m_exp_err   = 1'b0;
    logic [31:0] m_mem [DEPTH];

    initial begin
        logic [31:0] off;
        int          idx;
        forever begin
            @(posedge clka);
            if (rst) begin
                chk_en      = 1'b1;
                pend        = 1'b0;
                m_exp_valid = 1'b0;
                free_cyc    = cyc + 1;
            end else begin
                m_exp_valid = 1'b0;
                if (m_ready && bus_if.req_valid) begin
                    pend      = 1'b1;
                    p_we      = bus_if.req_we;
                    p_addr    = bus_if.req_addr;
                    p_wdata   = bus_if.req_wdata;
`ifdef BYTE_WRITE_EN
                    p_strb    = bus_if.req_strb;
`else
                    p_strb    = 4'hF;
`endif
                    commit_at = cyc + W;
                    free_cyc  = cyc + W + 2;
                end
                if (pend && commit_at == cyc) begin
                    pend        = 1'b0;
                    m_exp_valid = 1'b1;
                    off         = p_addr - BASE;
                    m_exp_err   = (p_addr % 4 != 0) || (p_addr < BASE) || (off / 4 >= DEPTH);
                    m_exp_rdata = 32'd0;
                    if (!m_exp_err) begin
                        idx = int'(off / 4);
                        if (p_we) begin
                            for (int b = 0; b < 4; b++)
                                if (p_strb[b]) m_mem[idx][8*b +: 8] = p_wdata[8*b +: 8];
                        end else begin
                            m_exp_rdata = m_mem[idx];
                        end
                    end
                end
            end
            cyc++;
            m_ready = (cyc >= free_cyc);
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clka);
            if (chk_en) begin
                chk("req_ready", 32'(bus_if.req_ready), 32'(m_ready));
                chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(m_exp_valid));
                if (m_exp_valid) begin
                    chk("rsp_rdata", bus_if.rsp_rdata, m_exp_rdata);
                    chk("rsp_err", 32'(bus_if.rsp_err), 32'(m_exp_err));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int rst_at,
                       output int lat, output logic [31:0] rd, output logic er);
        int k;
        lat = 0; rd = 32'd0; er = 1'b0;
        @(negedge clka);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = data;
`ifdef BYTE_WRITE_EN
        bus_if.req_strb  = strb;
`else
        if (strb == 4'hx) lat = 0;
`endif
        k = 0;
        while (!m_ready && k < 100) begin
            @(negedge clka);
            k++;
        end
        if (k >= 100) timeout("accept");
        @(negedge clka);
        // Scramble the fields after accept so a missing latch shows up.
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'($urandom);
        bus_if.req_addr  = $urandom;
        bus_if.req_wdata = $urandom;
        if (rst_at >= 0) begin
            repeat (rst_at) @(negedge clka);
            rst = 1'b1;
            @(negedge clka);
            rst = 1'b0;
        end else begin
            lat = 1;
            while (!bus_if.rsp_valid && lat < W + 20) begin
                @(negedge clka);
                lat++;
            end
            if (!bus_if.rsp_valid) timeout("response");
            rd = bus_if.rsp_rdata;
            er = bus_if.rsp_err;
        end
    endtask

    initial begin
        int          lat, rlow, seen, k;
        int          acc_c [3];
        logic [31:0] rd, a;
        logic        er;
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 32'd0;
        bus_if.req_wdata = 32'd0;
`ifdef BYTE_WRITE_EN
        bus_if.req_strb  = 4'hF;
`endif
        repeat (3) @(negedge clka);
        chk("reset_ready", 32'(bus_if.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus_if.rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(bus_if.rsp_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            txn(1'b1, BASE + 32'(i) * 4, $urandom, 4'hF, -1, lat, rd, er);

        // Write then read back with the documented latency.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, -1, lat, rd, er);
        chk("t1_wr_lat", 32'(lat), 32'd3);
        chk("t1_wr_rdata", rd, 32'd0);
        chk("t1_wr_err", 32'(er), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, -1, lat, rd, er);
        chk("t1_rd_lat", 32'(lat), 32'd3);
        chk("t1_rd_rdata", rd, 32'hDEADBEEF);
        chk("t1_rd_err", 32'(er), 32'd0);

        // Misaligned write is rejected and leaves memory untouched.
        txn(1'b1, 32'h13, 32'h12345678, 4'hF, -1, lat, rd, er);
        chk("t2_mis_err", 32'(er), 32'd1);
        chk("t2_mis_rdata", rd, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, -1, lat, rd, er);
        chk("t2_rd_rdata", rd, 32'hDEADBEEF);

        // Range boundaries.
        txn(1'b0, 32'h400, 32'h0, 4'hF, -1, lat, rd, er);
        chk("t3_oor_err", 32'(er), 32'd1);
        chk("t3_oor_rdata", rd, 32'd0);
        txn(1'b0, 32'h3FC, 32'h0, 4'hF, -1, lat, rd, er);
        chk("t3_last_err", 32'(er), 32'd0);
        txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, -1, lat, rd, er);
        chk("t3_top_err", 32'(er), 32'd1);

        // Back-to-back reads with req_valid held high.
        rlow = 0;
        @(negedge clka);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus_if.req_addr = BASE + 32'(j) * 4;
            k = 0;
            while (!m_ready && k < 50) begin
                if (!bus_if.req_ready) rlow++;
                @(negedge clka);
                k++;
            end
            if (k >= 50) timeout("t4_accept");
            acc_c[j] = cyc;
            @(negedge clka);
        end
        bus_if.req_valid = 1'b0;
        chk("t4_gap01", 32'(acc_c[1] - acc_c[0]), 32'd4);
        chk("t4_gap12", 32'(acc_c[2] - acc_c[1]), 32'd4);
        chk("t4_ready_low", 32'(rlow), 32'd6);
        repeat (W + 2) @(negedge clka);

        // Reset while BUSY discards the write.
        txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, -1, lat, rd, er);
        txn(1'b1, 32'h20, 32'h00000001, 4'hF, 0, lat, rd, er);
        seen = 0;
        for (int j = 0; j < W + 3; j++) begin
            if (bus_if.rsp_valid) seen++;
            @(negedge clka);
        end
        chk("t5_no_rsp", 32'(seen), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'hF, -1, lat, rd, er);
        chk("t5_rd_rdata", rd, 32'hCAFEF00D);

`ifdef BYTE_WRITE_EN
        txn(1'b1, 32'h30, 32'h11223344, 4'hF, -1, lat, rd, er);
        txn(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, -1, lat, rd, er);
        txn(1'b0, 32'h30, 32'h0, 4'h0, -1, lat, rd, er);
        chk("t6_strb_rdata", rd, 32'h11BB33DD);
        txn(1'b1, 32'h30, 32'h99999999, 4'b0000, -1, lat, rd, er);
        chk("t6_nostrb_err", 32'(er), 32'd0);
        txn(1'b0, 32'h30, 32'h0, 4'h0, -1, lat, rd, er);
        chk("t6_nostrb_rdata", rd, 32'h11BB33DD);
`endif

        // Randomized traffic with occasional mid-flight resets.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE + ($urandom_range(0, DEPTH - 1) << 2) + 32'($urandom_range(1, 3));
                1:       a = BASE + 32'(DEPTH) * 4 + ($urandom_range(0, 1023) << 2);
                default: a = BASE + ($urandom_range(0, DEPTH - 1) << 2);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clka);
            txn(1'($urandom), a, $urandom, 4'($urandom),
                ($urandom_range(0, 14) == 0) ? $urandom_range(0, W - 1) : -1,
                lat, rd, er);
        end
        repeat (W + 4) @(negedge clka);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
